// File: rtl/pipe_ctrl_if.sv
// Handshake/status bundle between the pipeline controller and the core stages.
interface pipe_ctrl_if #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned PERF_W  = 32
);
    logic               stallreq_id;
    logic               ex_mc_start;
    logic [CNT_W-1:0]   ex_mc_cycles;
    logic               excep_valid;
    logic [31:0]        excep_pc;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;
    logic               ex_mc_busy;
    logic               ex_mc_done;
    logic [PERF_W-1:0]  stall_cycles;

    // Core side: raises requests, consumes stall/flush.
    modport master (
        output stallreq_id, ex_mc_start, ex_mc_cycles, excep_valid, excep_pc,
        input  stall, flush, new_pc, ex_mc_busy, ex_mc_done, stall_cycles
    );

    // Controller side.
    modport slave (
        input  stallreq_id, ex_mc_start, ex_mc_cycles, excep_valid, excep_pc,
        output stall, flush, new_pc, ex_mc_busy, ex_mc_done, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall vector, multi-cycle EX sequencing, exception flush,
// saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 6,
    parameter int unsigned PERF_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    // EX hold covers PC..EX; load-use hold covers PC..ID.
    localparam logic [STALL_W-1:0] STALL_EX = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_ID = STALL_W'(6'b000111);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PERF_W-1:0]  perf_q;
    logic               stall_ex;
    logic [STALL_W-1:0] stall_c;

    // State and down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an exception aborts any op in progress.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_ex = 1'b0;
        if (bus.excep_valid) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ex_mc_start && (bus.ex_mc_cycles != '0)) begin
                        stall_ex = 1'b1;
                        cnt_d    = bus.ex_mc_cycles;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    stall_ex = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stall/flush outputs by priority: exception > EX multi-cycle > load-use.
    always_comb begin
        stall_c        = '0;
        bus.flush      = 1'b0;
        bus.new_pc     = '0;
        if (rst) begin
            if (bus.excep_valid) begin
                bus.flush  = 1'b1;
                bus.new_pc = bus.excep_pc;
            end else if (stall_ex) begin
                stall_c = STALL_EX;
            end else if (bus.stallreq_id) begin
                stall_c = STALL_ID;
            end
        end
        bus.stall      = stall_c;
        bus.ex_mc_busy = (state_q == BUSY);
        bus.ex_mc_done = (state_q == DONE);
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (stall_c[0] && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign bus.stall_cycles = perf_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// against a timing-window reference model.
module tb_pipe_ctrl;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned PERF_W  = 8;
    localparam int          PMAX    = (1 << PERF_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.STALL_W(STALL_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();
    pipe_ctrl #(.STALL_W(STALL_W), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: an accepted op is a window [t, t+n] of EX stall,
    // BUSY over [t+1, t+n], done pulse at t+n+1; new op only after that.
    int cyc    = 0;
    bit op_act = 1'b0;
    int op_t   = 0;
    int op_n   = 0;
    int perf   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit sr, input bit st, input int n, input bit ex, input logic [31:0] pc);
        bus.stallreq_id  = sr;
        bus.ex_mc_start  = st;
        bus.ex_mc_cycles = CNT_W'(n);
        bus.excep_valid  = ex;
        bus.excep_pc     = pc;
    endtask

    // Check one cycle against the model, then advance across the clock edge.
    task automatic step();
        int          exp_stall;
        bit          inwin, busy_e, done_e, ex, sr, st;
        int          n;
        logic [31:0] pc;
        #1;
        ex = bus.excep_valid;
        sr = bus.stallreq_id;
        st = bus.ex_mc_start;
        n  = int'(bus.ex_mc_cycles);
        pc = bus.excep_pc;
        if (op_act && cyc > op_t + op_n + 1) op_act = 1'b0;
        if (!op_act && st && n != 0 && !ex) begin
            op_act = 1'b1;
            op_t   = cyc;
            op_n   = n;
        end
        inwin  = op_act && cyc >= op_t && cyc <= op_t + op_n;
        busy_e = op_act && cyc >= op_t + 1 && cyc <= op_t + op_n;
        done_e = op_act && cyc == op_t + op_n + 1;
        exp_stall = ex ? 0 : (inwin ? 'h0F : (sr ? 'h07 : 0));
        chk("stall",        64'(bus.stall),        64'(exp_stall));
        chk("flush",        64'(bus.flush),        64'(ex));
        chk("new_pc",       64'(bus.new_pc),       ex ? 64'(pc) : 64'd0);
        chk("ex_mc_busy",   64'(bus.ex_mc_busy),   64'(busy_e));
        chk("ex_mc_done",   64'(bus.ex_mc_done),   64'(done_e));
        chk("stall_cycles", 64'(bus.stall_cycles), 64'(perf));
        @(posedge clk);
        if (exp_stall[0]) perf = (perf >= PMAX) ? PMAX : perf + 1;
        if (ex) op_act = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        op_act = 1'b0;
        perf   = 0;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 32'h0);
        #2;
        chk("rst_stall",  64'(bus.stall),        64'd0);
        chk("rst_busy",   64'(bus.ex_mc_busy),   64'd0);
        chk("rst_done",   64'(bus.ex_mc_done),   64'd0);
        chk("rst_perf",   64'(bus.stall_cycles), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle after reset.
        repeat (10) step();

        // Load-use for 3 cycles.
        set_in(1, 0, 0, 0, 32'h0);
        repeat (3) step();
        set_in(0, 0, 0, 0, 32'h0);
        chk("perf_loaduse", 64'(bus.stall_cycles), 64'd3);
        step();

        // 4-cycle op held until done.
        set_in(0, 1, 4, 0, 32'h0);
        repeat (5) step();
        chk("done_at_T5", 64'(bus.ex_mc_done), 64'd1);
        set_in(0, 0, 0, 0, 32'h0);
        step();
        step();
        chk("perf_mc", 64'(bus.stall_cycles), 64'd8);

        // Same op aborted by an exception at T+2.
        set_in(0, 1, 4, 0, 32'h0);
        repeat (2) step();
        set_in(0, 1, 4, 1, 32'h0000_0100);
        step();
        set_in(0, 0, 0, 0, 32'h0);
        repeat (4) step();

        // Zero-length op.
        set_in(0, 1, 0, 0, 32'h0);
        step();
        set_in(0, 0, 0, 0, 32'h0);
        chk("zero_busy", 64'(bus.ex_mc_busy), 64'd0);
        step();

        // Load-use during BUSY keeps the EX pattern.
        set_in(0, 1, 3, 0, 32'h0);
        step();
        set_in(1, 1, 3, 0, 32'h0);
        repeat (3) step();
        set_in(0, 0, 0, 0, 32'h0);
        repeat (2) step();

        // Reset mid-BUSY, between clock edges.
        set_in(0, 1, 5, 0, 32'h0);
        repeat (2) step();
        #2;
        set_in(1, 1, 5, 1, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(bus.stall),        64'd0);
        chk("mid_rst_flush", 64'(bus.flush),        64'd0);
        chk("mid_rst_newpc", 64'(bus.new_pc),       64'd0);
        chk("mid_rst_busy",  64'(bus.ex_mc_busy),   64'd0);
        chk("mid_rst_perf",  64'(bus.stall_cycles), 64'd0);
        apply_reset();
        repeat (2) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 20),
                   int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 3),
                   $urandom);
            step();
        end

        // Long load-use run drives the counter into saturation.
        apply_reset();
        set_in(1, 0, 0, 0, 32'h0);
        repeat (PMAX + 20) step();
        chk("perf_sat", 64'(bus.stall_cycles), 64'(PMAX));
        set_in(0, 0, 0, 0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Generates the per-stage stall vector that gates the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences multi-cycle EX operations (div, madd/msub) with a cycle counter.
- Issues pipeline flush plus redirect PC on exceptions, and keeps a saturating stall-cycle performance counter.

Parameters:
- STALL_W, 6, stall vector width; bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.
- CNT_W, 6, width of multi-cycle length and internal down-counter.
- PERF_W, 32, width of stall-cycle performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stallreq_id  in  1  load-use hazard request from ID.
- ex_mc_start  in  1  EX holds a multi-cycle op this cycle.
- ex_mc_cycles  in  CNT_W  number of extra EX cycles the op needs; sampled with start.
- excep_valid  in  1  exception committed this cycle.
- excep_pc  in  32  handler address.
- stall  out  STALL_W  stage hold vector (combinational).
- flush  out  1  clear all pipeline registers (combinational).
- new_pc  out  32  redirect target, valid when flush=1, else 0.
- ex_mc_busy  out  1  multi-cycle FSM in BUSY.
- ex_mc_done  out  1  registered one-cycle pulse: EX result ready.
- stall_cycles  out  PERF_W  count of cycles with stall[0]=1, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE, counter=0, ex_mc_done=0, stall_cycles=0.
  - While rst=0, combinational outputs are forced: stall=0, flush=0, new_pc=0.
- Priority, highest first: excep_valid > EX multi-cycle > stallreq_id.
- Exception:
  - flush=1, new_pc=excep_pc, stall=0 in the same cycle.
  - Next edge: FSM->IDLE, counter=0, ex_mc_done=0. Aborts any op in progress, including in DONE.
- FSM states IDLE, BUSY, DONE:
  - IDLE, ex_mc_start=1 and ex_mc_cycles!=0: stall=6'b001111 this cycle; load counter=ex_mc_cycles; ->BUSY.
  - IDLE, ex_mc_start=1 and ex_mc_cycles==0: single-cycle op. No stall, no state change, no done pulse.
  - BUSY: stall=6'b001111; counter decrements each cycle; when counter==1 ->DONE (counter->0).
  - DONE: ex_mc_done=1 for exactly this cycle; EX stall released (stall=0 from EX path); ->IDLE.
  - ex_mc_start in BUSY/DONE is ignored; EX keeps start high until done, and a new op is accepted only from IDLE.
- Timing: start at cycle T with N cycles -> stall high T..T+N (N+1 cycles), BUSY T+1..T+N, ex_mc_done=1 at T+N+1.
- Load-use: stallreq_id=1 with no higher-priority source -> stall=6'b000111. If asserted during BUSY, the EX pattern 001111 wins (superset).
- ex_mc_busy=1 exactly when state==BUSY.
- stall_cycles increments at each edge where stall[0]=1 and rst=1; holds at all-ones (no wrap).
- Combinational outputs depend only on current state and inputs; no output glitch requirements beyond single-cycle settling.

Test Plan:
- Release reset, drive nothing -> stall=0, flush=0, new_pc=0, ex_mc_done=0, stall_cycles=0 for 10 cycles.
- stallreq_id=1 for 3 cycles -> stall=6'b000111 those 3 cycles; stall_cycles=3.
- ex_mc_start=1, ex_mc_cycles=4 at T, held until done -> stall=6'b001111 T..T+4; ex_mc_busy T+1..T+4; ex_mc_done=1 only at T+5; stall_cycles=5.
- Same op with excep_valid=1, excep_pc=32'h0000_0100 at T+2 -> flush=1, new_pc=32'h100, stall=0 at T+2; IDLE at T+3; no ex_mc_done pulse.
- ex_mc_cycles=0 with start -> no stall, no busy, no done. Separately: stallreq_id=1 during BUSY -> stall stays 6'b001111.
- Pull rst low mid-BUSY (between clock edges) -> immediate stall=0, ex_mc_busy=0, stall_cycles=0. Preload stall_cycles near max via long stall -> saturates at all-ones.
